// File: rtl/axi_xbar_clr_pkg.sv
// Shared definitions for the crossbar clear controller.
//   clr_state_e : controller FSM states (IDLE -> DRAIN -> CLEAR -> DONE).
//   cnt_width() : bit width needed to hold the values 0..max_val.
package axi_xbar_clr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } clr_state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/axi_xbar_txn_cnt.sv
// Saturating up/down counter of outstanding transactions for one port and
// one direction.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear to 0 (has priority over inc/dec)
//   inc_i, dec_i  : request issued / response completed; both together hold
//   full_o        : count == MaxTxns
//   empty_o       : count == 0
// Incrementing at MaxTxns or decrementing at 0 is a protocol error. It is
// caught by an assertion and the count holds instead of wrapping.
module axi_xbar_txn_cnt
  import axi_xbar_clr_pkg::*;
#(
  parameter int unsigned MaxTxns = 24
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned CntW = cnt_width(MaxTxns);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);

  logic [CntW-1:0] cnt_reg;
  logic [CntW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr_i) begin
      cnt_next = '0;
    end else if (inc_i && !dec_i && (cnt_reg != MaxCnt)) begin
      cnt_next = cnt_reg + 1'b1;
    end else if (dec_i && !inc_i && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign full_o  = (cnt_reg == MaxCnt);
  assign empty_o = (cnt_reg == '0);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(inc_i && !dec_i && !clr_i && (cnt_reg == MaxCnt)));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(dec_i && !inc_i && !clr_i && (cnt_reg == '0)));

endmodule

// File: rtl/axi_xbar_clr_ctrl.sv
// Clear controller for a clearable AXI crossbar. It tracks outstanding
// write and read transactions per slave port, and on a four-phase clear
// request it closes the AW/AR gates, waits for the ports to drain (or for a
// timeout), pulses the crossbar clear, and acknowledges.
// Sits beside the crossbar: xbar_clr_o drives the crossbar clr_i, and the
// crossbar clear acknowledge returns on xbar_clr_ack_i.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   clr_req_i / clr_ack_o    : four-phase clear handshake with the requester
//   aw_hs_i, b_hs_i          : per-port AW accepted / B delivered
//   ar_hs_i, r_last_hs_i     : per-port AR accepted / last R beat delivered
//   w_last_hs_i              : reserved, not used
//   gate_aw_o, gate_ar_o     : per-port request to hold AW/AR valid+ready low
//   xbar_clr_o               : clear strobe to the crossbar (held in CLEAR)
//   xbar_clr_ack_i           : crossbar clear acknowledge
//   busy_o                   : a clear sequence is in progress
//   timeout_o                : sticky, last drain gave up on the timeout
module axi_xbar_clr_ctrl
  import axi_xbar_clr_pkg::*;
#(
  parameter int unsigned NumPorts      = 4,
  parameter int unsigned MaxTxns       = 24,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_req_i,
  output logic                clr_ack_o,
  input  logic [NumPorts-1:0] aw_hs_i,
  input  logic [NumPorts-1:0] w_last_hs_i,
  input  logic [NumPorts-1:0] b_hs_i,
  input  logic [NumPorts-1:0] ar_hs_i,
  input  logic [NumPorts-1:0] r_last_hs_i,
  output logic [NumPorts-1:0] gate_aw_o,
  output logic [NumPorts-1:0] gate_ar_o,
  output logic                xbar_clr_o,
  input  logic                xbar_clr_ack_i,
  output logic                busy_o,
  output logic                timeout_o
);

  localparam int unsigned TmoW = cnt_width(TimeoutCycles);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  clr_state_e      state_reg, state_next;
  logic [TmoW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic            timeout_reg, timeout_next;

  logic [NumPorts-1:0] wr_full, wr_empty;
  logic [NumPorts-1:0] rd_full, rd_empty;
  logic                all_empty;
  logic                cnt_clr;

  // W-last handshakes are reserved for future use.
  logic unused_w_last;
  assign unused_w_last = ^w_last_hs_i;

  // The crossbar has dropped all state once it acknowledges the clear, so
  // the tracking counters are zeroed on the same edge.
  assign cnt_clr   = (state_reg == CLEAR) && xbar_clr_ack_i;
  assign all_empty = (&wr_empty) && (&rd_empty);

  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
    axi_xbar_txn_cnt #(
      .MaxTxns (MaxTxns)
    ) u_wr_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (cnt_clr),
      .inc_i   (aw_hs_i[gi]),
      .dec_i   (b_hs_i[gi]),
      .full_o  (wr_full[gi]),
      .empty_o (wr_empty[gi])
    );

    axi_xbar_txn_cnt #(
      .MaxTxns (MaxTxns)
    ) u_rd_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (cnt_clr),
      .inc_i   (ar_hs_i[gi]),
      .dec_i   (r_last_hs_i[gi]),
      .full_o  (rd_full[gi]),
      .empty_o (rd_empty[gi])
    );
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      tmo_cnt_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tmo_cnt_reg <= tmo_cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  // Next-state logic. Once a clear has started it runs to DONE whatever
  // clr_req_i does; only DONE waits for the request to drop.
  always_comb begin
    state_next   = state_reg;
    tmo_cnt_next = tmo_cnt_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      IDLE: begin
        if (clr_req_i) begin
          state_next   = DRAIN;
          tmo_cnt_next = '0;
          timeout_next = 1'b0;
        end
      end
      DRAIN: begin
        // Drained wins over a timeout that lands on the same cycle.
        if (all_empty) begin
          state_next = CLEAR;
        end else if (tmo_cnt_reg == TmoLast) begin
          state_next   = CLEAR;
          timeout_next = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end
      CLEAR: begin
        if (xbar_clr_ack_i) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!clr_req_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs, decoded from registered state and counts only.
  always_comb begin
    busy_o     = (state_reg != IDLE);
    xbar_clr_o = (state_reg == CLEAR);
    clr_ack_o  = (state_reg == DONE);
    gate_aw_o  = wr_full | {NumPorts{state_reg != IDLE}};
    gate_ar_o  = rd_full | {NumPorts{state_reg != IDLE}};
  end

  assign timeout_o = timeout_reg;

endmodule
